// File: rtl/issue_queue.sv
// In-order issue queue: buffers fetched instructions and issues the head to the
// adder or load/store reservation station when the target reports a free line.
module issue_queue #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 16
) (
    input  logic                     Clock,
    input  logic                     Reset,
    input  logic [WIDTH-1:0]         instIn,
    input  logic                     instInValid,
    output logic                     instInReady,
    input  logic                     disponivelAdd,
    input  logic                     disponivelMem,
    output logic [WIDTH-1:0]         instruction,
    output logic                     Adderin,
    output logic                     Memin,
    output logic                     illegal,
    output logic                     stall,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    head_reg, tail_reg;
    logic [CW-1:0]    count_reg, count_next;
    logic [WIDTH-1:0] instruction_reg;
    logic             adderin_reg, memin_reg, illegal_reg;
    logic             lock_add_reg, lock_mem_reg;

    logic [WIDTH-1:0] head_inst;
    logic [3:0]       opcode;
    logic             head_valid, is_add, is_mem;
    logic             issue_add, issue_mem, drop_illegal;
    logic             push, pop;

    assign head_inst   = mem[head_reg];
    assign opcode      = head_inst[3:0];
    assign head_valid  = (count_reg != '0);
    assign instInReady = (count_reg < CW'(DEPTH));

    always_comb begin
        is_add       = (opcode == 4'b0000) || (opcode == 4'b0001);
        is_mem       = (opcode == 4'b0010) || (opcode == 4'b0011);
        issue_add    = head_valid && is_add && disponivelAdd && !lock_add_reg;
        issue_mem    = head_valid && is_mem && disponivelMem && !lock_mem_reg;
        drop_illegal = head_valid && !is_add && !is_mem;
        stall        = head_valid &&
                       ((is_add && (!disponivelAdd || lock_add_reg)) ||
                        (is_mem && (!disponivelMem || lock_mem_reg)));
        push         = instInValid && instInReady;
        pop          = issue_add || issue_mem || drop_illegal;
    end

    always_comb begin
        count_next = count_reg;
        if (push && !pop)
            count_next = count_reg + CW'(1);
        else if (pop && !push)
            count_next = count_reg - CW'(1);
    end

    // Storage carries no reset; occupancy alone decides which entries are live.
    always_ff @(posedge Clock) begin
        if (push)
            mem[tail_reg] <= instIn;
    end

    // Lockout is just the issue strobe delayed: it masks the cycle in which the
    // station's free-line report has not yet seen the entry we handed it.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            head_reg        <= '0;
            tail_reg        <= '0;
            count_reg       <= '0;
            instruction_reg <= '0;
            adderin_reg     <= 1'b0;
            memin_reg       <= 1'b0;
            illegal_reg     <= 1'b0;
            lock_add_reg    <= 1'b0;
            lock_mem_reg    <= 1'b0;
        end else begin
            count_reg    <= count_next;
            adderin_reg  <= issue_add;
            memin_reg    <= issue_mem;
            illegal_reg  <= drop_illegal;
            lock_add_reg <= issue_add;
            lock_mem_reg <= issue_mem;
            if (push)
                tail_reg <= tail_reg + PW'(1);
            if (pop)
                head_reg <= head_reg + PW'(1);
            if (issue_add || issue_mem)
                instruction_reg <= head_inst;
        end
    end

    assign instruction = instruction_reg;
    assign Adderin     = adderin_reg;
    assign Memin       = memin_reg;
    assign illegal     = illegal_reg;
    assign count       = count_reg;

endmodule

// File: tb/tb_issue_queue.sv
// Bench for issue_queue: a queue-level reference model checked on every falling
// edge, plus directed scenarios with hand-computed expectations.
module tb_issue_queue;

    logic        Clock = 1'b0;
    logic        Reset;
    logic [15:0] instIn;
    logic        instInValid;
    logic        instInReady;
    logic        disponivelAdd;
    logic        disponivelMem;
    logic [15:0] instruction;
    logic        Adderin;
    logic        Memin;
    logic        illegal;
    logic        stall;
    logic [3:0]  count;

    issue_queue #(.DEPTH(8), .WIDTH(16)) dut (
        .Clock(Clock), .Reset(Reset),
        .instIn(instIn), .instInValid(instInValid), .instInReady(instInReady),
        .disponivelAdd(disponivelAdd), .disponivelMem(disponivelMem),
        .instruction(instruction), .Adderin(Adderin), .Memin(Memin),
        .illegal(illegal), .stall(stall), .count(count)
    );

    always #5 Clock = ~Clock;

    int vectors    = 0;
    int miscompares = 0;

    // Reference model: the queue contents plus what each output must be.
    logic [15:0] mq[$];
    logic [15:0] m_instr;
    logic        m_add, m_mem, m_ill;
    bit          check_en = 0;

    int add_pulses = 0, mem_pulses = 0, ill_pulses = 0, consec_add = 0;
    bit prev_add = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int target(input logic [15:0] w);
        // 1 = adder, 2 = load/store, 0 = unknown opcode
        if (w[3:0] == 4'd0 || w[3:0] == 4'd1) return 1;
        if (w[3:0] == 4'd2 || w[3:0] == 4'd3) return 2;
        return 0;
    endfunction

    always @(posedge Clock) begin
        int sz;
        bit ia, im, il;
        sz = mq.size();
        if (Reset) begin
            mq.delete();
            m_instr = '0;
            m_add = 0; m_mem = 0; m_ill = 0;
        end else begin
            // A station issued to on the previous edge is still locked out now.
            ia = (sz > 0) && target(mq[0]) == 1 && disponivelAdd && !m_add;
            im = (sz > 0) && target(mq[0]) == 2 && disponivelMem && !m_mem;
            il = (sz > 0) && target(mq[0]) == 0;
            if (ia || im) m_instr = mq[0];
            if (instInValid && sz < 8) mq.push_back(instIn);
            if (ia || im || il) void'(mq.pop_front());
            m_add = ia; m_mem = im; m_ill = il;
        end
    end

    always @(negedge Clock) begin
        bit m_stall;
        if (check_en) begin
            m_stall = 0;
            if (mq.size() > 0) begin
                if (target(mq[0]) == 1) m_stall = !disponivelAdd || m_add;
                if (target(mq[0]) == 2) m_stall = !disponivelMem || m_mem;
            end
            chk("count",       32'(count),       32'(mq.size()));
            chk("instInReady", 32'(instInReady), 32'(mq.size() < 8));
            chk("instruction", 32'(instruction), 32'(m_instr));
            chk("Adderin",     32'(Adderin),     32'(m_add));
            chk("Memin",       32'(Memin),       32'(m_mem));
            chk("illegal",     32'(illegal),     32'(m_ill));
            chk("stall",       32'(stall),       32'(m_stall));
            if (Adderin && prev_add) consec_add++;
            prev_add = Adderin;
            add_pulses += int'(Adderin);
            mem_pulses += int'(Memin);
            ill_pulses += int'(illegal);
        end
    end

    task automatic cyc(input int n = 1);
        repeat (n) begin
            @(negedge Clock);
            #1;
        end
    endtask

    task automatic push(input logic [15:0] d);
        instIn = d;
        instInValid = 1;
        cyc();
        instInValid = 0;
    endtask

    int a0, m0, i0;

    initial begin
        Reset = 1; instIn = '0; instInValid = 0;
        disponivelAdd = 0; disponivelMem = 0;
        cyc(2);
        Reset = 0;
        check_en = 1;
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_ready", 32'(instInReady), 32'd1);
        chk("rst_stall", 32'(stall), 32'd0);

        // Single add: issued on the edge after the push edge, for one cycle.
        disponivelAdd = 1;
        push(16'h1C00);
        chk("t1_pre_add", 32'(Adderin), 32'd0);
        cyc();
        chk("t1_add", 32'(Adderin), 32'd1);
        chk("t1_instr", 32'(instruction), 32'h1C00);
        cyc();
        chk("t1_add_drop", 32'(Adderin), 32'd0);
        chk("t1_count", 32'(count), 32'd0);

        // Three back-to-back adds: lockout spaces the strobes.
        a0 = add_pulses;
        push(16'h0400); push(16'h0480); push(16'h0500);
        cyc(8);
        chk("t2_pulses", 32'(add_pulses - a0), 32'd3);
        chk("t2_consec", 32'(consec_add), 32'd0);
        chk("t2_last", 32'(instruction), 32'h0500);

        // Add blocked at head keeps the ready ld behind it.
        disponivelAdd = 0; disponivelMem = 1;
        a0 = add_pulses; m0 = mem_pulses;
        push(16'h0600); push(16'h0012);
        cyc(2);
        chk("t3_stall", 32'(stall), 32'd1);
        chk("t3_no_mem", 32'(mem_pulses - m0), 32'd0);
        disponivelAdd = 1;
        cyc();
        chk("t3_add", 32'(Adderin), 32'd1);
        cyc();
        chk("t3_mem", 32'(Memin), 32'd1);
        chk("t3_instr", 32'(instruction), 32'h0012);
        cyc(2);
        chk("t3_counts", 32'((add_pulses - a0) * 16 + (mem_pulses - m0)), 32'h11);

        // Fill past capacity with both stations busy.
        disponivelAdd = 0; disponivelMem = 0;
        a0 = add_pulses; m0 = mem_pulses;
        instInValid = 1;
        for (int i = 0; i < 9; i++) begin
            instIn = 16'h1000 + 16'(i << 4) + ((i % 2) ? 16'h2 : 16'h0);
            cyc();
        end
        instInValid = 0;
        chk("t4_full_count", 32'(count), 32'd8);
        chk("t4_full_ready", 32'(instInReady), 32'd0);
        chk("t4_full_stall", 32'(stall), 32'd1);
        disponivelAdd = 1; disponivelMem = 1;
        cyc(14);
        chk("t4_strobes", 32'((add_pulses - a0) + (mem_pulses - m0)), 32'd8);
        chk("t4_last", 32'(instruction), 32'h1072);
        chk("t4_empty", 32'(count), 32'd0);

        // Unknown opcode is discarded, the following sub still issues.
        a0 = add_pulses; i0 = ill_pulses;
        push(16'h0007); push(16'h2481);
        cyc(4);
        chk("t5_illegal", 32'(ill_pulses - i0), 32'd1);
        chk("t5_add", 32'(add_pulses - a0), 32'd1);
        chk("t5_instr", 32'(instruction), 32'h2481);

        // Reset mid-stream with a strobe high.
        disponivelAdd = 0;
        push(16'h0100); push(16'h0180); push(16'h0200); push(16'h0280);
        disponivelAdd = 1;
        begin
            int n = 0;
            while (!Adderin && n < 10) begin cyc(); n++; end
            chk("t6_wait_add", 32'(Adderin), 32'd1);
        end
        Reset = 1;
        cyc();
        Reset = 0;
        chk("t6_count", 32'(count), 32'd0);
        chk("t6_add", 32'(Adderin), 32'd0);
        chk("t6_instr", 32'(instruction), 32'd0);
        a0 = add_pulses;
        cyc(6);
        chk("t6_no_more", 32'(add_pulses - a0), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
